// File: rtl/bram_pipe_dp_if.sv
// rtl/bram_pipe_dp_if.sv - dual-port block RAM bus bundle (ports A/B, collision status)
interface bram_pipe_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) ();
  logic                  rdena;
  logic                  rdenb;
  logic                  wrena;
  logic                  wrenb;
  logic [STRB_WIDTH-1:0] wrstrba;
  logic [STRB_WIDTH-1:0] wrstrbb;
  logic [ADDR_WIDTH-1:0] addra;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] dina;
  logic [DATA_WIDTH-1:0] dinb;
  logic [DATA_WIDTH-1:0] douta;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  valida;
  logic                  validb;
  logic                  collision;
  logic                  collision_clr;

  modport master (
    output rdena, rdenb, wrena, wrenb, wrstrba, wrstrbb,
           addra, addrb, dina, dinb, collision_clr,
    input  douta, doutb, valida, validb, collision
  );

  modport slave (
    input  rdena, rdenb, wrena, wrenb, wrstrba, wrstrbb,
           addra, addrb, dina, dinb, collision_clr,
    output douta, doutb, valida, validb, collision
  );
endinterface

// File: rtl/bram_pipe_dp.sv
// rtl/bram_pipe_dp.sv - true dual-port byte-strobed RAM with pipelined reads; optional BRAM_PIPE_DP_COLLISION_EN
module bram_pipe_dp #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0
) (
  input  logic         clk,
  input  logic         rst,
  bram_pipe_dp_if.slave bus
);
  localparam int LANE_W = DATA_WIDTH / STRB_WIDTH;
  localparam int DEPTH  = 1 << ADDR_WIDTH;

  // Storage is deliberately never reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Index 0 is port A, index 1 is port B.
  logic [1:0]            rden;
  logic [1:0]            wren;
  logic [STRB_WIDTH-1:0] strb    [2];
  logic [ADDR_WIDTH-1:0] addr    [2];
  logic [DATA_WIDTH-1:0] din     [2];
  logic [DATA_WIDTH-1:0] mask    [2];
  logic [DATA_WIDTH-1:0] rd_word [2];

  logic [READ_LATENCY-1:0] vld_q [2];
  logic [READ_LATENCY-1:0] vld_d [2];
  logic [DATA_WIDTH-1:0]   dat_q [2][READ_LATENCY];
  logic [DATA_WIDTH-1:0]   dat_d [2][READ_LATENCY];

  assign rden    = {bus.rdenb, bus.rdena};
  assign wren    = {bus.wrenb, bus.wrena};
  assign strb[0] = bus.wrstrba;
  assign strb[1] = bus.wrstrbb;
  assign addr[0] = bus.addra;
  assign addr[1] = bus.addrb;
  assign din[0]  = bus.dina;
  assign din[1]  = bus.dinb;

  // Lane masks and the word each port captures on a read (old word, or own-port merge in WRITE_MODE 1).
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      mask[p] = '0;
      for (int i = 0; i < STRB_WIDTH; i++) begin
        mask[p][i*LANE_W +: LANE_W] = {LANE_W{strb[p][i]}};
      end
      rd_word[p] = mem_q[addr[p]];
      if (WRITE_MODE == 1 && wren[p]) begin
        rd_word[p] = (rd_word[p] & ~mask[p]) | (din[p] & mask[p]);
      end
    end
  end

  // Lane writes; port A is applied last so it owns lanes both ports strobe at the same address.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (wren[1] && strb[1][i]) begin
        mem_q[addr[1]][i*LANE_W +: LANE_W] <= din[1][i*LANE_W +: LANE_W];
      end
      if (wren[0] && strb[0][i]) begin
        mem_q[addr[0]][i*LANE_W +: LANE_W] <= din[0][i*LANE_W +: LANE_W];
      end
    end
  end

  // Read pipeline next state: each data stage loads only behind a valid, so the last stage holds between pulses.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      vld_d[p] = vld_q[p];
      for (int k = 0; k < READ_LATENCY; k++) begin
        int   km1;
        logic src_v;
        km1   = (k == 0) ? 0 : k - 1;
        src_v = (k == 0) ? rden[p] : vld_q[p][km1];
        vld_d[p][k] = src_v;
        dat_d[p][k] = dat_q[p][k];
        if (src_v) begin
          dat_d[p][k] = (k == 0) ? rd_word[p] : dat_q[p][km1];
        end
      end
    end
  end

  // Read pipeline registers; reset drops reads in flight and zeroes the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        vld_q[p] <= '0;
        for (int k = 0; k < READ_LATENCY; k++) begin
          dat_q[p][k] <= '0;
        end
      end
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign bus.douta  = dat_q[0][READ_LATENCY-1];
  assign bus.doutb  = dat_q[1][READ_LATENCY-1];
  assign bus.valida = vld_q[0][READ_LATENCY-1];
  assign bus.validb = vld_q[1][READ_LATENCY-1];

`ifdef BRAM_PIPE_DP_COLLISION_EN
  logic coll_hit;
  logic coll_d;
  logic coll_q;

  // Same address with a write on one port and any access on the other; a new hit beats a clear.
  always_comb begin
    coll_hit = (addr[0] == addr[1]) &&
               ((wren[0] && (rden[1] || wren[1])) || (wren[1] && (rden[0] || wren[0])));
    coll_d   = coll_hit | (coll_q & ~bus.collision_clr);
  end

  // Sticky collision flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_q <= 1'b0;
    end else begin
      coll_q <= coll_d;
    end
  end

  assign bus.collision = coll_q;
`else
  logic unused_collision_clr;
  assign unused_collision_clr = bus.collision_clr;
  assign bus.collision        = 1'b0;
`endif
endmodule

// File: doc/bram_pipe_dp.md
BRAM_PIPE_DP -- requirements
Module: bram_pipe_dp

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of STRB_WIDTH.
REQ-002 Parameter ADDR_WIDTH, default 10: address width; depth SHALL be 2**ADDR_WIDTH words.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8: byte-lane count, lane width DATA_WIDTH/STRB_WIDTH.
REQ-004 Parameter READ_LATENCY, default 1: cycles from accepted read to data; legal range 1..4.
REQ-005 Parameter WRITE_MODE, default 0: same-port read+write returns 0 = old data, 1 = new merged data.
REQ-006 One clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  sole clock, all logic on rising edge.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 rdena / rdenb  in  1  per-port read request.
REQ-010 wrena / wrenb  in  1  per-port write request.
REQ-011 wrstrba / wrstrbb  in  STRB_WIDTH  per-lane write enables.
REQ-012 addra / addrb  in  ADDR_WIDTH  word address.
REQ-013 dina / dinb  in  DATA_WIDTH  write data.
REQ-014 douta / doutb  out  DATA_WIDTH  read data, registered.
REQ-015 valida / validb  out  1  one-cycle pulse marking douta/doutb valid.
REQ-016 collision  out  1  sticky address-collision flag (see Configuration).
REQ-017 collision_clr  in  1  synchronous clear of collision.

Function
REQ-018 Ports A and B SHALL be fully independent, both read/write capable, same clk.
REQ-019 Write: on edge with wren=1, each lane i with wrstrb[i]=1 SHALL be updated; other lanes unchanged; wrstrb=0 SHALL be a no-op.
REQ-020 Read: rden=1 at edge N SHALL produce dout and valid=1 at edge N+READ_LATENCY; a READ_LATENCY-deep valid/data pipeline, one read accepted per cycle per port, no stalls.
REQ-021 dout SHALL hold its last value between valid pulses.
REQ-022 Same-port rden=1 and wren=1: write SHALL be performed and read SHALL return pre-write word (WRITE_MODE=0) or post-merge word (WRITE_MODE=1).
REQ-023 Cross-port read of an address written by the other port in the same cycle SHALL return the pre-write word.
REQ-024 Both ports write same address same cycle: lanes strobed by A SHALL take dina; lanes strobed only by B SHALL take dinb.
REQ-025 Address arithmetic SHALL be ADDR_WIDTH unsigned with no wrap or bounds logic; every address legal.
REQ-026 rd/wr with X on unused inputs (addr/din when enables low) SHALL not alter memory or outputs.

Reset
REQ-027 rst=1 SHALL immediately clear valida, validb, all valid pipeline stages, douta, doutb and collision to 0.
REQ-028 Memory contents SHALL NOT be reset; reads in flight at reset SHALL be discarded (no valid pulse after rst release).
REQ-029 Requests on the first edge after rst deasserts SHALL be accepted normally.

Configuration
REQ-030 Macro BRAM_PIPE_DP_COLLISION_EN defined: collision SHALL set one cycle after any edge where addra==addrb with either port writing while the other reads or writes; SHALL stay set until collision_clr=1 at an edge (set wins over simultaneous clear).
REQ-031 Macro undefined: collision SHALL be constant 0, collision_clr ignored, no detection logic synthesised.

Verification
REQ-032 Write A addr 0x005 din 0xDEADBEEF strb 0xF; then rdena addr 0x005, READ_LATENCY=3 -> valida and douta=0xDEADBEEF exactly 3 edges after read, valida low otherwise.
REQ-033 Mem[0x010]=0x11223344; A writes 0xAABBCCDD strb 0x5 -> readback 0x11BB33DD.
REQ-034 Mem[0x020]=0x0; same edge rdena+wrena 0xCAFEF00D strb 0xF -> douta=0x0 with WRITE_MODE=0, 0xCAFEF00D with WRITE_MODE=1; later read 0xCAFEF00D.
REQ-035 Both ports write 0x030, A 0x11111111 strb 0x3, B 0x22222222 strb 0xE -> mem 0x22221111; with macro collision=1 next cycle, held until collision_clr; without macro collision stays 0.
REQ-036 Back-to-back reads 0x000..0x007 on B each cycle, rst pulsed mid-stream -> validb/doutb 0 immediately, no stale valid after release, memory intact on re-read.
